// File: rtl/ifmd_window_fetch.sv
// ifmd_window_fetch: walks every 3x3 window (stride 1, no padding) of an 8x8 map
// held in the IFMD RAM. It issues registered RAM reads and streams the pixels,
// each tagged with its window position, through a 2-entry skid buffer to the PE.
module ifmd_window_fetch #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_first,
  output logic              pix_last,
  output logic              frame_last,
  output logic [2:0]        win_row,
  output logic [2:0]        win_col
);

  localparam logic [2:0]        OrowMax = 3'(IMG_H - K);
  localparam logic [2:0]        OcolMax = 3'(IMG_W - K);
  localparam logic [1:0]        KMax    = 2'(K - 1);
  localparam logic [ADDR_W-1:0] ImgWA   = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       first;
    logic       last;
    logic       flast;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] pix;
    tag_t              tag;
  } entry_t;

  state_e            state_q, state_d;
  logic [2:0]        orow_q, orow_d, ocol_q, ocol_d;
  logic [1:0]        kr_q, kr_d, kc_q, kc_d;
  logic [ADDR_W-1:0] last_addr_q, cur_addr, row_sum, col_sum;
  logic              inflight_q;
  tag_t              tag_q, tag_d;
  entry_t            fifo_q [2];
  entry_t            head;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic [2:0]        occ;
  logic              issue, push, pop;

  // Tap address and the tags that travel with it through the read latency.
  always_comb begin
    row_sum    = ADDR_W'(orow_q) + ADDR_W'(kr_q);
    col_sum    = ADDR_W'(ocol_q) + ADDR_W'(kc_q);
    cur_addr   = row_sum * ImgWA + col_sum;
    tag_d.row   = orow_q;
    tag_d.col   = ocol_q;
    tag_d.first = (kr_q == '0) && (kc_q == '0);
    tag_d.last  = (kr_q == KMax) && (kc_q == KMax);
    tag_d.flast = tag_d.last && (orow_q == OrowMax) && (ocol_q == OcolMax);
  end

  // Skid-buffer occupancy: push on returning read data, pop on PE handshake.
  always_comb begin
    push    = inflight_q;
    pop     = (count_q != '0) && pix_ready;
    occ     = {1'b0, count_q} + {2'b00, inflight_q};
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Frame FSM plus window/tap loop nest; a read issues only when a buffer slot is guaranteed.
  always_comb begin
    state_d = state_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          orow_d  = '0;
          ocol_d  = '0;
          kr_d    = '0;
          kc_d    = '0;
        end
      end
      StFetch: begin
        issue = (occ < 3'd2) || pop;
        if (issue) begin
          if (kc_q != KMax) begin
            kc_d = kc_q + 2'd1;
          end else begin
            kc_d = '0;
            if (kr_q != KMax) begin
              kr_d = kr_q + 2'd1;
            end else begin
              kr_d = '0;
              if (ocol_q != OcolMax) begin
                ocol_d = ocol_q + 3'd1;
              end else begin
                ocol_d = '0;
                if (orow_q != OrowMax) begin
                  orow_d = orow_q + 3'd1;
                end else begin
                  orow_d  = '0;
                  state_d = StDrain;
                end
              end
            end
          end
        end
      end
      // No reads issue here, so an empty next-state buffer means the frame is fully delivered.
      StDrain: begin
        if (count_d == '0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counters, read pipeline and skid-buffer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      orow_q      <= '0;
      ocol_q      <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      tag_q       <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q    <= state_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      inflight_q <= issue;
      count_q    <= count_d;
      if (issue) begin
        last_addr_q <= cur_addr;
        tag_q       <= tag_d;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {ram_data, tag_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Outputs: RAM port, status, and the buffer head with its tags.
  always_comb begin
    head       = fifo_q[rd_ptr_q];
    busy       = (state_q == StFetch) || (state_q == StDrain);
    done       = (state_q == StDone);
    ram_read   = issue;
    ram_addr   = issue ? cur_addr : last_addr_q;
    pix_valid  = (count_q != '0);
    pix_out    = head.pix;
    win_row    = head.tag.row;
    win_col    = head.tag.col;
    pix_first  = pix_valid && head.tag.first;
    pix_last   = pix_valid && head.tag.last;
    frame_last = pix_valid && head.tag.flast;
  end

endmodule

// File: tb/tb_ifmd_window_fetch.sv
// Bench for ifmd_window_fetch: ramp-filled RAM model, scoreboard of expected
// tagged pixels, scenario tasks for nominal, backpressure, ignored start and reset.
module tb_ifmd_window_fetch;

  typedef struct packed {
    logic [7:0] pix;
    logic [2:0] row;
    logic [2:0] col;
    logic       first;
    logic       last;
    logic       flast;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, busy, done, ram_read;
  logic [5:0] ram_addr;
  logic [7:0] ram_data, pix_out;
  logic       pix_valid, pix_ready, pix_first, pix_last, frame_last;
  logic [2:0] win_row, win_col;

  logic [7:0] mem [64];
  exp_t       exp_q [$];
  int         vectors = 0;
  int         miscompares = 0;
  int         first9 [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
  int         last9  [9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};
  int         w23    [9] = '{19, 20, 21, 27, 28, 29, 35, 36, 37};

  always #5 clk = ~clk;

  ifmd_window_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .ram_read   (ram_read),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_first  (pix_first),
    .pix_last   (pix_last),
    .frame_last (frame_last),
    .win_row    (win_row),
    .win_col    (win_col)
  );

  // Registered-read RAM model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (ram_read) ram_data <= mem[ram_addr];
  end

  // Expected stream for one frame, in window-major, tap-minor order.
  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++) begin
            e.pix   = mem[(r + kr) * 8 + c + kc];
            e.row   = 3'(r);
            e.col   = 3'(c);
            e.first = (kr == 0) && (kc == 0);
            e.last  = (kr == 2) && (kc == 2);
            e.flast = e.last && (r == 5) && (c == 5);
            exp_q.push_back(e);
          end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    #1;
    vectors++;
    if ({busy, done, ram_read, ram_addr, pix_valid, pix_first, pix_last, frame_last,
         win_row, win_col, pix_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b rd=%b addr=%0d v=%b f=%b l=%b fl=%b row=%0d col=%0d, required all 0",
               busy, done, ram_read, ram_addr, pix_valid, pix_first, pix_last, frame_last,
               win_row, win_col);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int   n = 0, reads = 0, dones = 0, done_cyc = -1, first_valid = -1, req;
    exp_t e, got;
    exp_q.delete();
    push_frame();
    pix_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 335; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      if (cyc == 1) begin
        vectors++;
        if ({busy, ram_read, ram_addr} !== {1'b1, 1'b1, 6'd0}) begin
          miscompares++;
          $display("FAIL first_issue: got busy=%b rd=%b addr=%0d, required 1 1 0",
                   busy, ram_read, ram_addr);
        end
      end
      if (ram_read) reads++;
      if (done) begin
        dones++;
        done_cyc = cyc;
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_at_done: got %b, required 0", busy);
        end
      end
      if (pix_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (pix_valid === 1'b1 && pix_ready) begin
        got = {pix_out, win_row, win_col, pix_first, pix_last, frame_last};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL nominal_underflow: got pixel %0d, required none", pix_out);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL nominal_pixel[%0d]: got %h, required %h", n, got, e);
          end
        end
        req = -1;
        if (n < 9) req = first9[n];
        else if (n >= 135 && n < 144) req = w23[n - 135];
        else if (n >= 315) req = last9[n - 315];
        if (req >= 0) begin
          vectors++;
          if (pix_out !== 8'(req)) begin
            miscompares++;
            $display("FAIL tap_value[%0d]: got %0d, required %0d", n, pix_out, req);
          end
        end
        if (n >= 135 && n < 144) begin
          vectors++;
          if ({win_row, win_col, pix_first, pix_last} !==
              {3'd2, 3'd3, (n == 135), (n == 143)}) begin
            miscompares++;
            $display("FAIL window23_tags[%0d]: got row=%0d col=%0d f=%b l=%b, required 2 3 %b %b",
                     n, win_row, win_col, pix_first, pix_last, (n == 135), (n == 143));
          end
        end
        n++;
      end
    end
    vectors++;
    if (first_valid != 3) begin
      miscompares++;
      $display("FAIL first_valid_cycle: got %0d, required 3", first_valid);
    end
    vectors++;
    if (reads != 324) begin
      miscompares++;
      $display("FAIL read_count: got %0d, required 324", reads);
    end
    vectors++;
    if (dones != 1 || done_cyc != 327) begin
      miscompares++;
      $display("FAIL done_pulse: got %0d pulses at cycle %0d, required 1 at 327", dones, done_cyc);
    end
    vectors++;
    if (n != 324) begin
      miscompares++;
      $display("FAIL nominal_count: got %0d, required 324", n);
    end
  endtask

  task automatic test_backpressure();
    int   n = 0, dones = 0, outst = 0, max_outst = 0, cyc = 0;
    logic held = 1'b0;
    exp_t e, got, prev = '0;
    exp_q.delete();
    push_frame();
    pix_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (dones == 0 && cyc < 2000) begin
      cyc++;
      if (cyc > 1) @(negedge clk);
      pix_ready = 1'($urandom_range(0, 1));
      #1;
      got = {pix_out, win_row, win_col, pix_first, pix_last, frame_last};
      if (held) begin
        vectors++;
        if (pix_valid !== 1'b1 || got !== prev) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b %h, required v=1 %h", pix_valid, got, prev);
        end
      end
      if (outst > max_outst) max_outst = outst;
      if (ram_read) outst++;
      if (pix_valid === 1'b1 && pix_ready) begin
        outst--;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_underflow: got pixel %0d, required none", pix_out);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL bp_pixel[%0d]: got %h, required %h", n, got, e);
          end
        end
        n++;
      end
      held = (pix_valid === 1'b1) && !pix_ready;
      prev = got;
      if (done) dones++;
    end
    vectors++;
    if (n != 324 || dones != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_frame: got %0d pixels, %0d done, %0d left, required 324 1 0",
               n, dones, exp_q.size());
    end
    vectors++;
    if (max_outst > 2) begin
      miscompares++;
      $display("FAIL bp_occupancy: got %0d, required <= 2", max_outst);
    end
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int n = 0, reads = 0, dones = 0;
    pix_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 360; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start = (cyc == 50) || (cyc == 327);
      #1;
      if (ram_read) reads++;
      if (done) dones++;
      if (pix_valid === 1'b1 && pix_ready) n++;
    end
    start = 1'b0;
    vectors++;
    if (dones != 1 || reads != 324 || n != 324 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_ignored: got done=%0d reads=%0d pix=%0d busy=%b, required 1 324 324 0",
               dones, reads, n, busy);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0, cyc = 0;
    pix_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n < 100 && cyc < 400) begin
      cyc++;
      if (cyc > 1) @(negedge clk);
      #1;
      if (pix_valid === 1'b1 && pix_ready) n++;
    end
    // Assert reset between edges: outputs must clear with no clock edge.
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, ram_read, ram_addr, pix_valid, pix_first, pix_last, frame_last,
         win_row, win_col, pix_out} !== '0 || n != 100) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b rd=%b addr=%0d v=%b out=%0d row=%0d col=%0d n=%0d, required all 0 n=100",
               busy, ram_read, ram_addr, pix_valid, pix_out, win_row, win_col, n);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      vectors++;
      if (c == 1 && {ram_read, ram_addr, pix_valid} !== {1'b1, 6'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL restart_issue: got rd=%b addr=%0d v=%b, required 1 0 0",
                 ram_read, ram_addr, pix_valid);
      end
      if (c == 2 && pix_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL restart_early_valid: got %b, required 0", pix_valid);
      end
      if (c == 3 && {pix_valid, pix_out, pix_first, win_row, win_col} !==
                    {1'b1, 8'd0, 1'b1, 3'd0, 3'd0}) begin
        miscompares++;
        $display("FAIL restart_first_pixel: got v=%b out=%0d f=%b row=%0d col=%0d, required 1 0 1 0 0",
                 pix_valid, pix_out, pix_first, win_row, win_col);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    test_reset();
    test_nominal();
    test_backpressure();
    test_start_ignored();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
